// File: rtl/wb_stage.sv
// Write-back stage: MEM/WB pipeline register, load extraction, result select, retired-instruction counter.
// Optional write-before-read bypass toward ID is enabled by defining WB_BYPASS_EN.
module wb_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic        mem_reg_write,
  input  logic [4:0]  mem_rd,
  input  logic [1:0]  mem_wb_sel,
  input  logic [2:0]  mem_funct3,
  input  logic [31:0] mem_alu_result,
  input  logic [31:0] mem_read_data,
  input  logic [31:0] mem_pc4,
  output logic        rf_reg_write,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_wd,
  output logic        wb_valid,
  output logic [31:0] instret
`ifdef WB_BYPASS_EN
  ,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [31:0] id_rd1_raw,
  input  logic [31:0] id_rd2_raw,
  output logic [31:0] id_rd1,
  output logic [31:0] id_rd2
`endif
);

  localparam logic [1:0] SEL_ALU  = 2'b00;
  localparam logic [1:0] SEL_LOAD = 2'b01;
  localparam logic [1:0] SEL_PC4  = 2'b10;

  logic        valid_r;
  logic        reg_write_r;
  logic [4:0]  rd_r;
  logic [1:0]  wb_sel_r;
  logic [2:0]  funct3_r;
  logic [31:0] alu_r;
  logic [31:0] rdata_r;
  logic [31:0] pc4_r;
  logic [31:0] instret_r;
  logic [31:0] load_s;
  logic [31:0] wd_s;
  logic        we_s;

  // Extract and extend the addressed byte/halfword of an aligned word; unsupported widths give zero.
  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] word);
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] res_v;
    case (off)
      2'd0:    byte_v = word[7:0];
      2'd1:    byte_v = word[15:8];
      2'd2:    byte_v = word[23:16];
      2'd3:    byte_v = word[31:24];
      default: byte_v = 8'h00;
    endcase
    half_v = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  res_v = {{24{byte_v[7]}}, byte_v};
      3'b100:  res_v = {24'h000000, byte_v};
      3'b001:  res_v = {{16{half_v[15]}}, half_v};
      3'b101:  res_v = {16'h0000, half_v};
      3'b010:  res_v = word;
      default: res_v = 32'h0000_0000;
    endcase
    return res_v;
  endfunction

  // MEM/WB capture register and retired-instruction counter; reset discards the in-flight slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_r     <= 1'b0;
      reg_write_r <= 1'b0;
      rd_r        <= 5'd0;
      wb_sel_r    <= 2'b00;
      funct3_r    <= 3'b000;
      alu_r       <= 32'h0000_0000;
      rdata_r     <= 32'h0000_0000;
      pc4_r       <= 32'h0000_0000;
      instret_r   <= 32'h0000_0000;
    end else begin
      valid_r     <= mem_valid;
      reg_write_r <= mem_reg_write;
      rd_r        <= mem_rd;
      wb_sel_r    <= mem_wb_sel;
      funct3_r    <= mem_funct3;
      alu_r       <= mem_alu_result;
      rdata_r     <= mem_read_data;
      pc4_r       <= mem_pc4;
      if (valid_r) begin
        instret_r <= instret_r + 32'd1;
      end else begin
        instret_r <= instret_r;
      end
    end
  end

  // Result select; the reserved source code writes zero.
  always_comb begin
    load_s = load_extend(funct3_r, alu_r[1:0], rdata_r);
    wd_s   = 32'h0000_0000;
    case (wb_sel_r)
      SEL_ALU:  wd_s = alu_r;
      SEL_LOAD: wd_s = load_s;
      SEL_PC4:  wd_s = pc4_r;
      default:  wd_s = 32'h0000_0000;
    endcase
  end

  assign we_s         = valid_r & reg_write_r & (rd_r != 5'd0);
  assign rf_reg_write = we_s;
  assign rf_rd        = rd_r;
  assign rf_wd        = wd_s;
  assign wb_valid     = valid_r;
  assign instret      = instret_r;

`ifdef WB_BYPASS_EN
  // Forward the write in progress to same-cycle ID reads; x0 never matches because we_s excludes it.
  always_comb begin
    id_rd1 = id_rd1_raw;
    id_rd2 = id_rd2_raw;
    if (we_s && (id_rs1 == rd_r)) begin
      id_rd1 = wd_s;
    end else begin
      id_rd1 = id_rd1_raw;
    end
    if (we_s && (id_rs2 == rd_r)) begin
      id_rd2 = wd_s;
    end else begin
      id_rd2 = id_rd2_raw;
    end
  end
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed vector table, corner-case sequences, random stimulus vs model.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_valid, mem_reg_write;
  logic [4:0]  mem_rd;
  logic [1:0]  mem_wb_sel;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_alu_result, mem_read_data, mem_pc4;
  logic        rf_reg_write, wb_valid;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wd, instret;
  logic [4:0]  id_rs1, id_rs2;
  logic [31:0] id_rd1_raw, id_rd2_raw, id_rd1, id_rd2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  wb_stage dut (
    .clk(clk), .reset(reset),
    .mem_valid(mem_valid), .mem_reg_write(mem_reg_write), .mem_rd(mem_rd),
    .mem_wb_sel(mem_wb_sel), .mem_funct3(mem_funct3), .mem_alu_result(mem_alu_result),
    .mem_read_data(mem_read_data), .mem_pc4(mem_pc4),
    .rf_reg_write(rf_reg_write), .rf_rd(rf_rd), .rf_wd(rf_wd), .wb_valid(wb_valid),
    .instret(instret)
`ifdef WB_BYPASS_EN
    , .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd1_raw(id_rd1_raw), .id_rd2_raw(id_rd2_raw),
    .id_rd1(id_rd1), .id_rd2(id_rd2)
`endif
  );

  // Reference model: the instruction currently in WB and the count of instructions that have left WB.
  typedef struct {
    bit          valid;
    bit          we;
    bit [4:0]    rd;
    bit [1:0]    sel;
    bit [2:0]    f3;
    bit [31:0]   alu;
    bit [31:0]   rdata;
    bit [31:0]   pc4;
  } instr_t;

  instr_t      m_wb;
  bit [31:0]   m_instret;

  typedef struct {
    instr_t    in;
    bit        exp_we;
    bit [4:0]  exp_rd;
    bit [31:0] exp_wd;
    bit        exp_valid;
  } vec_t;

  vec_t vecs[10];

  function automatic bit [31:0] ref_load(bit [2:0] f3, bit [1:0] off, bit [31:0] word);
    bit [31:0] b, h;
    b = (word >> (int'(off) * 8)) & 32'h0000_00FF;
    h = (word >> (off[1] ? 16 : 0)) & 32'h0000_FFFF;
    if (f3 == 3'd0) return (b >= 32'h80) ? b - 32'h100 : b;
    if (f3 == 3'd4) return b;
    if (f3 == 3'd1) return (h >= 32'h8000) ? h - 32'h1_0000 : h;
    if (f3 == 3'd5) return h;
    if (f3 == 3'd2) return word;
    return 32'h0;
  endfunction

  function automatic bit [31:0] ref_wd(instr_t i);
    if (i.sel == 2'd0) return i.alu;
    if (i.sel == 2'd1) return ref_load(i.f3, i.alu[1:0], i.rdata);
    if (i.sel == 2'd2) return i.pc4;
    return 32'h0;
  endfunction

  function automatic bit ref_we(instr_t i);
    return i.valid && i.we && (i.rd != 5'd0);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(instr_t i);
    mem_valid      = i.valid;
    mem_reg_write  = i.we;
    mem_rd         = i.rd;
    mem_wb_sel     = i.sel;
    mem_funct3     = i.f3;
    mem_alu_result = i.alu;
    mem_read_data  = i.rdata;
    mem_pc4        = i.pc4;
  endtask

  task automatic model_clear();
    m_wb      = '{default: 0};
    m_instret = 32'h0;
  endtask

  task automatic check_model(string tag);
    check({tag, ".rf_reg_write"}, 32'(rf_reg_write), 32'(ref_we(m_wb)));
    check({tag, ".rf_rd"},        32'(rf_rd),        32'(m_wb.rd));
    check({tag, ".rf_wd"},        rf_wd,             ref_wd(m_wb));
    check({tag, ".wb_valid"},     32'(wb_valid),     32'(m_wb.valid));
    check({tag, ".instret"},      instret,           m_instret);
  endtask

  // One clock: model advances with the edge, outputs compared on the falling edge.
  task automatic cycle(instr_t i, string tag);
    drive(i);
    @(posedge clk);
    if (reset) model_clear();
    else begin
      if (m_wb.valid) m_instret = m_instret + 32'd1;
      m_wb = i;
    end
    @(negedge clk);
    check_model(tag);
  endtask

  task automatic bypass_check(string tag);
    bit [31:0] e1, e2;
    #1;
    e1 = (ref_we(m_wb) && id_rs1 == m_wb.rd) ? ref_wd(m_wb) : id_rd1_raw;
    e2 = (ref_we(m_wb) && id_rs2 == m_wb.rd) ? ref_wd(m_wb) : id_rd2_raw;
    check({tag, ".id_rd1"}, id_rd1, e1);
    check({tag, ".id_rd2"}, id_rd2, e2);
  endtask

  function automatic instr_t rand_instr();
    instr_t r;
    r.valid = ($urandom_range(0, 3) != 0);
    r.we    = $urandom_range(0, 1);
    r.rd    = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
    r.sel   = 2'($urandom_range(0, 3));
    r.f3    = 3'($urandom_range(0, 7));
    r.alu   = $urandom;
    r.rdata = $urandom;
    r.pc4   = $urandom;
    return r;
  endfunction

  instr_t t;

  initial begin
    //               valid we  rd     sel    f3      alu            rdata          pc4           we  rd     wd             v
    vecs[0] = '{'{1, 1, 5'd5,  2'd0, 3'd0, 32'h0000_1234, 32'h0,         32'h0},         1, 5'd5,  32'h0000_1234, 1};
    vecs[1] = '{'{1, 1, 5'd10, 2'd1, 3'd0, 32'h0000_1003, 32'h80FF_00AA, 32'h0},         1, 5'd10, 32'hFFFF_FF80, 1};
    vecs[2] = '{'{1, 1, 5'd11, 2'd1, 3'd5, 32'h0000_2002, 32'h80FF_00AA, 32'h0},         1, 5'd11, 32'h0000_80FF, 1};
    vecs[3] = '{'{1, 1, 5'd12, 2'd1, 3'd3, 32'h0000_2000, 32'h80FF_00AA, 32'h0},         1, 5'd12, 32'h0000_0000, 1};
    vecs[4] = '{'{1, 1, 5'd0,  2'd2, 3'd0, 32'h0000_0040, 32'h0,         32'h0000_0104}, 0, 5'd0,  32'h0000_0104, 1};
    vecs[5] = '{'{0, 1, 5'd3,  2'd0, 3'd0, 32'h0000_0055, 32'h0,         32'h0},         0, 5'd3,  32'h0000_0055, 0};
    vecs[6] = '{'{1, 1, 5'd9,  2'd3, 3'd0, 32'h0000_0077, 32'h0,         32'h0000_0200}, 1, 5'd9,  32'h0000_0000, 1};
    vecs[7] = '{'{1, 1, 5'd13, 2'd1, 3'd2, 32'h0000_0003, 32'h80FF_00AA, 32'h0},         1, 5'd13, 32'h80FF_00AA, 1};
    vecs[8] = '{'{1, 1, 5'd14, 2'd1, 3'd1, 32'h0000_0000, 32'h1234_8001, 32'h0},         1, 5'd14, 32'hFFFF_8001, 1};
    vecs[9] = '{'{1, 0, 5'd15, 2'd1, 3'd4, 32'h0000_0001, 32'h1234_8001, 32'h0},         0, 5'd15, 32'h0000_0080, 1};

    id_rs1 = 5'd0; id_rs2 = 5'd0; id_rd1_raw = 32'h0; id_rd2_raw = 32'h0;
    t = '{default: 0};
    drive(t);
    reset = 1'b1;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_model("reset");
    reset = 1'b0;

    // Directed table; instret must track the model across the whole sequence.
    for (int i = 0; i < 10; i++) begin
      cycle(vecs[i].in, $sformatf("vec%0d", i));
      check($sformatf("vec%0d.tbl_we", i), 32'(rf_reg_write), 32'(vecs[i].exp_we));
      check($sformatf("vec%0d.tbl_rd", i), 32'(rf_rd), 32'(vecs[i].exp_rd));
      check($sformatf("vec%0d.tbl_wd", i), rf_wd, vecs[i].exp_wd);
      check($sformatf("vec%0d.tbl_valid", i), 32'(wb_valid), 32'(vecs[i].exp_valid));
    end

    // Counter wrap: preset to all-ones while a valid instruction sits in WB.
    t = '{default: 0};
    t.valid = 1'b1;
    cycle(t, "wrap_fill");
    force dut.instret_r = 32'hFFFF_FFFF;
    #1;
    release dut.instret_r;
    m_instret = 32'hFFFF_FFFF;
    #1;
    check("wrap_preset", instret, 32'hFFFF_FFFF);
    cycle(t, "wrap");
    check("wrap_zero", instret, 32'h0000_0000);

    // Reset pulse between edges while WB holds a writing instruction.
    t = '{default: 0};
    t.valid = 1'b1; t.we = 1'b1; t.rd = 5'd4; t.alu = 32'h0000_00AB;
    cycle(t, "pre_reset");
    check("pre_reset.we_high", 32'(rf_reg_write), 32'h1);
    #2 reset = 1'b1;
    #1;
    check("midrst.rf_reg_write", 32'(rf_reg_write), 32'h0);
    check("midrst.wb_valid", 32'(wb_valid), 32'h0);
    check("midrst.instret", instret, 32'h0);
    check("midrst.rf_wd", rf_wd, 32'h0);
    check("midrst.rf_rd", 32'(rf_rd), 32'h0);
    model_clear();
    #1 reset = 1'b0;
    t.rd = 5'd6; t.alu = 32'h0000_0CDE;
    cycle(t, "post_reset");
    cycle(t, "post_reset2");

`ifdef WB_BYPASS_EN
    t = '{default: 0};
    t.valid = 1'b1; t.we = 1'b1; t.rd = 5'd7; t.alu = 32'hDEAD_BEEF;
    cycle(t, "byp_wr");
    id_rs2 = 5'd7; id_rd2_raw = 32'h0; id_rs1 = 5'd8; id_rd1_raw = 32'h1111_2222;
    #1;
    check("byp.id_rd2_fwd", id_rd2, 32'hDEAD_BEEF);
    check("byp.id_rd1_raw", id_rd1, 32'h1111_2222);
`endif

    // Random stream against the model.
    for (int i = 0; i < 400; i++) begin
      cycle(rand_instr(), $sformatf("rnd%0d", i));
`ifdef WB_BYPASS_EN
      id_rs1 = ($urandom_range(0, 1) != 0) ? rf_rd : 5'($urandom_range(0, 31));
      id_rs2 = ($urandom_range(0, 1) != 0) ? rf_rd : 5'($urandom_range(0, 31));
      id_rd1_raw = $urandom;
      id_rd2_raw = $urandom;
      bypass_check($sformatf("rnd%0d", i));
`endif
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-003 SHALL have port mem_valid, input, 1 bit: MEM-stage slot holds a real instruction (0 = bubble).
REQ-004 SHALL have port mem_reg_write, input, 1 bit: instruction writes rd.
REQ-005 SHALL have port mem_rd, input, 5 bits: destination register index.
REQ-006 SHALL have port mem_wb_sel, input, 2 bits: result source; 00 ALU, 01 load, 10 pc4, 11 reserved.
REQ-007 SHALL have port mem_funct3, input, 3 bits: load width/sign field.
REQ-008 SHALL have port mem_alu_result, input, 32 bits: ALU result; bits [1:0] give the load byte offset.
REQ-009 SHALL have port mem_read_data, input, 32 bits: aligned data-memory word.
REQ-010 SHALL have port mem_pc4, input, 32 bits: PC+4 of the instruction.
REQ-011 SHALL have port rf_reg_write, output, 1 bit: register-file write enable.
REQ-012 SHALL have port rf_rd, output, 5 bits: register-file write index.
REQ-013 SHALL have port rf_wd, output, 32 bits: register-file write data.
REQ-014 SHALL have port wb_valid, output, 1 bit: WB slot holds a real instruction.
REQ-015 SHALL have port instret, output, 32 bits: retired-instruction counter.
REQ-016 SHALL have ports id_rs1 and id_rs2, input, 5 bits each: ID read indices (bypass only).
REQ-017 SHALL have ports id_rd1_raw and id_rd2_raw, input, 32 bits each: raw regfile read data (bypass only).
REQ-018 SHALL have ports id_rd1 and id_rd2, output, 32 bits each: bypassed read data (bypass only).

Function
REQ-019 SHALL capture all mem_* inputs into an internal MEM/WB register on every rising edge; one-cycle latency, no stall input.
REQ-020 SHALL drive rf_reg_write = reg_valid AND reg_reg_write AND (reg_rd != 0); writes to x0 are suppressed.
REQ-021 SHALL drive rf_rd = reg_rd and wb_valid = reg_valid, combinationally from the register.
REQ-022 SHALL select rf_wd by wb_sel: 00 ALU result, 01 extended load, 10 pc4, 11 zero.
REQ-023 SHALL extract loads at offset off = alu[1:0]: LB(000)/LBU(100) byte off, sign-/zero-extended; LH(001)/LHU(101) halfword at off[1], sign-/zero-extended; LW(010) whole word, offset ignored; funct3 011/110/111 yield zero.
REQ-024 SHALL increment instret by 1 at each rising edge where reg_valid=1, including x0 or non-writing instructions; wraps 0xFFFFFFFF to 0.
REQ-025 SHALL keep rf_reg_write at 0 for bubbles regardless of other captured fields.

Reset
REQ-026 SHALL, while reset=1, immediately clear reg_valid, reg_reg_write, reg_rd, reg_wb_sel, reg_funct3, all data fields and instret to 0; rf_reg_write=0, rf_rd=0, rf_wd=0, wb_valid=0, instret=0.
REQ-027 SHALL, on reset asserted mid-stream, discard the in-flight instruction (no write, no count); the first edge after release captures normally.

Configuration
REQ-028 SHALL, with macro WB_BYPASS_EN defined, drive id_rdN = rf_wd when rf_reg_write=1 and id_rsN == rf_rd, else id_rdN_raw (write-before-read bypass; x0 never bypassed by REQ-020).
REQ-029 SHALL, without WB_BYPASS_EN, omit ports id_rs1, id_rs2, id_rd1_raw, id_rd2_raw, id_rd1, id_rd2 and all bypass logic.

Verification
REQ-030 SHALL cover: valid, reg_write=1, rd=5, wb_sel=00, alu=0x1234 -> next cycle rf_reg_write=1, rf_rd=5, rf_wd=0x00001234, instret 0->1.
REQ-031 SHALL cover: LB, alu[1:0]=3, read_data=0x80FF00AA -> rf_wd=0xFFFFFF80; LHU, offset 2 -> 0x000080FF; funct3=011 -> 0.
REQ-032 SHALL cover: rd=0 with reg_write=1, wb_sel=10, pc4=0x104 -> rf_reg_write=0, instret still increments; bubble (mem_valid=0) -> no write, no increment.
REQ-033 SHALL cover: preload instret to 0xFFFFFFFF via valid stream, one more valid -> instret=0x00000000.
REQ-034 SHALL cover: reset pulsed between edges while wb_valid=1 -> rf_reg_write and wb_valid drop to 0 before the next edge; instret=0.
REQ-035 SHALL cover, with WB_BYPASS_EN: WB writes x7=0xDEADBEEF, id_rs2=7, id_rd2_raw=0 -> id_rd2=0xDEADBEEF; id_rs1=8 -> id_rd1=id_rd1_raw.
